// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester round-robin arbiter for the single-port, word-indexed data
//   memory. Port 0 is the core load/store unit and port 1 is the debug/DMA
//   master. An accepted request is latched, presented to the memory for one
//   ACCESS cycle, and answered with a one-cycle response pulse on the port
//   that was granted. The arbiter is the only driver of the memory's
//   addr/write_data/write_enable.
//
//   Optional feature macro: DMEM_ARB_BOUNDS_CHECK_EN
//     defined   : a latched address >= DEPTH suppresses the write, forces
//                 mem_addr to 0 and returns rsp_err = 1 with rsp_rdata = 0.
//     undefined : no bounds check; rsp_err is always 0.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   pX_req_valid/ready           request handshake (X = 0, 1)
//   pX_req_we/addr/wdata         request write flag, word address, write data
//   pX_rsp_valid/rdata/err       one-cycle response pulse with data and error
//   mem_addr/mem_wdata/mem_we    to the data memory
//   mem_rdata                    from the data memory, combinational on addr
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              p0_req_valid,
   output logic              p0_req_ready,
   input  logic              p0_req_we,
   input  logic [ADDR_W-1:0] p0_req_addr,
   input  logic [DATA_W-1:0] p0_req_wdata,
   output logic              p0_rsp_valid,
   output logic [DATA_W-1:0] p0_rsp_rdata,
   output logic              p0_rsp_err,
   input  logic              p1_req_valid,
   output logic              p1_req_ready,
   input  logic              p1_req_we,
   input  logic [ADDR_W-1:0] p1_req_addr,
   input  logic [DATA_W-1:0] p1_req_wdata,
   output logic              p1_rsp_valid,
   output logic [DATA_W-1:0] p1_rsp_rdata,
   output logic              p1_rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
`endif

   state_t              state_r;
   logic                last_grant_r;
   logic                grant_id_r;
   logic                we_r;
   logic                err_r;
   logic                mem_we_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [DATA_W-1:0]   mem_wdata_r;
   logic                p0_rsp_valid_r;
   logic [DATA_W-1:0]   p0_rsp_rdata_r;
   logic                p0_rsp_err_r;
   logic                p1_rsp_valid_r;
   logic [DATA_W-1:0]   p1_rsp_rdata_r;
   logic                p1_rsp_err_r;

   logic                grant_s;
   logic                accept_s;
   logic                sel_we_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_wdata_s;
   logic                oob_s;
   logic [DATA_W-1:0]   rsp_rdata_s;

   // Arbitration: pick the winner and select its request fields
   always_comb begin
      grant_s     = 1'b0;
      accept_s    = 1'b0;
      sel_we_s    = 1'b0;
      sel_addr_s  = {ADDR_W{1'b0}};
      sel_wdata_s = {DATA_W{1'b0}};
      // On a tie the port that did not win last time gets the grant.
      if (p0_req_valid && p1_req_valid) begin
         grant_s = ~last_grant_r;
      end else if (p0_req_valid) begin
         grant_s = 1'b0;
      end else begin
         grant_s = 1'b1;
      end
      if (grant_s) begin
         sel_we_s    = p1_req_we;
         sel_addr_s  = p1_req_addr;
         sel_wdata_s = p1_req_wdata;
      end else begin
         sel_we_s    = p0_req_we;
         sel_addr_s  = p0_req_addr;
         sel_wdata_s = p0_req_wdata;
      end
      // Ready is held low throughout reset and outside IDLE.
      if (reset_n && (state_r == ST_IDLE) && (p0_req_valid || p1_req_valid)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Address range check on the selected request
   always_comb begin
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      oob_s = ({1'b0, sel_addr_s} >= DEPTH_C);
`else
      oob_s = 1'b0;
`endif
   end

   // Response data: writes and rejected accesses return zero
   always_comb begin
      if (we_r || err_r) begin
         rsp_rdata_s = {DATA_W{1'b0}};
      end else begin
         rsp_rdata_s = mem_rdata;
      end
   end

   // Arbiter FSM with registered memory-side and response outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         last_grant_r   <= 1'b1;
         grant_id_r     <= 1'b0;
         we_r           <= 1'b0;
         err_r          <= 1'b0;
         mem_we_r       <= 1'b0;
         mem_addr_r     <= {ADDR_W{1'b0}};
         mem_wdata_r    <= {DATA_W{1'b0}};
         p0_rsp_valid_r <= 1'b0;
         p0_rsp_rdata_r <= {DATA_W{1'b0}};
         p0_rsp_err_r   <= 1'b0;
         p1_rsp_valid_r <= 1'b0;
         p1_rsp_rdata_r <= {DATA_W{1'b0}};
         p1_rsp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               p0_rsp_valid_r <= 1'b0;
               p1_rsp_valid_r <= 1'b0;
               if (accept_s) begin
                  grant_id_r   <= grant_s;
                  last_grant_r <= grant_s;
                  we_r         <= sel_we_s;
                  err_r        <= oob_s;
                  mem_we_r     <= sel_we_s & ~oob_s;
                  mem_addr_r   <= oob_s ? {ADDR_W{1'b0}} : sel_addr_s;
                  mem_wdata_r  <= sel_wdata_s;
                  state_r      <= ST_ACCESS;
               end else begin
                  state_r      <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               // Memory writes and read data is captured at this closing edge.
               mem_we_r <= 1'b0;
               state_r  <= ST_IDLE;
               if (grant_id_r) begin
                  p1_rsp_valid_r <= 1'b1;
                  p1_rsp_rdata_r <= rsp_rdata_s;
                  p1_rsp_err_r   <= err_r;
                  p0_rsp_valid_r <= 1'b0;
               end else begin
                  p0_rsp_valid_r <= 1'b1;
                  p0_rsp_rdata_r <= rsp_rdata_s;
                  p0_rsp_err_r   <= err_r;
                  p1_rsp_valid_r <= 1'b0;
               end
            end
            default: begin
               state_r        <= ST_IDLE;
               mem_we_r       <= 1'b0;
               p0_rsp_valid_r <= 1'b0;
               p1_rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign p0_req_ready = accept_s & ~grant_s;
   assign p1_req_ready = accept_s &  grant_s;

   // The write strobe is cut as soon as reset asserts so that a reset
   // landing on the ACCESS closing edge never commits the write.
   assign mem_we       = mem_we_r & reset_n;
   assign mem_addr     = mem_addr_r;
   assign mem_wdata    = mem_wdata_r;

   assign p0_rsp_valid = p0_rsp_valid_r;
   assign p0_rsp_rdata = p0_rsp_rdata_r;
   assign p0_rsp_err   = p0_rsp_err_r;
   assign p1_rsp_valid = p1_rsp_valid_r;
   assign p1_rsp_rdata = p1_rsp_rdata_r;
   assign p1_rsp_err   = p1_rsp_err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed testbench for dmem_arbiter with a 1024-word behavioural memory
//   whose reset contents are word[i] = i. Inputs change #1 after a rising
//   edge or at a falling edge; outputs are sampled at falling edges.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic        clk;
   logic        reset_n;
   logic        p0_req_valid, p0_req_ready, p0_req_we;
   logic [31:0] p0_req_addr, p0_req_wdata;
   logic        p0_rsp_valid, p0_rsp_err;
   logic [31:0] p0_rsp_rdata;
   logic        p1_req_valid, p1_req_ready, p1_req_we;
   logic [31:0] p1_req_addr, p1_req_wdata;
   logic        p1_rsp_valid, p1_rsp_err;
   logic [31:0] p1_rsp_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   logic [31:0] mem [0:1023];

   int err_cnt = 0;
   int chk_cnt = 0;

   dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .p0_req_valid (p0_req_valid),
      .p0_req_ready (p0_req_ready),
      .p0_req_we    (p0_req_we),
      .p0_req_addr  (p0_req_addr),
      .p0_req_wdata (p0_req_wdata),
      .p0_rsp_valid (p0_rsp_valid),
      .p0_rsp_rdata (p0_rsp_rdata),
      .p0_rsp_err   (p0_rsp_err),
      .p1_req_valid (p1_req_valid),
      .p1_req_ready (p1_req_ready),
      .p1_req_we    (p1_req_we),
      .p1_req_addr  (p1_req_addr),
      .p1_req_wdata (p1_req_wdata),
      .p1_rsp_valid (p1_rsp_valid),
      .p1_rsp_rdata (p1_rsp_rdata),
      .p1_rsp_err   (p1_rsp_err),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port memory: combinational read, write on rising edge
   assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'd0;
   always @(posedge clk) begin
      if (mem_we && (mem_addr < 32'd1024)) mem[mem_addr[9:0]] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int port, input logic v, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 0) begin
         p0_req_valid = v; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata;
      end else begin
         p1_req_valid = v; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata;
      end
   endtask

   // Single uncontended request from a falling edge through its response.
   task automatic issue(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_mem_we,
                        input logic [31:0] exp_mem_addr, input logic [31:0] exp_rdata,
                        input logic exp_err);
      drive(port, 1'b1, we, addr, wdata);
      #1;
      check("issue_ready", {p1_req_ready, p0_req_ready}, (port == 0) ? 64'd1 : 64'd2);
      @(posedge clk);
      #1 drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      check("access_mem_we", mem_we, exp_mem_we);
      check("access_mem_addr", mem_addr, exp_mem_addr);
      check("access_ready", {p1_req_ready, p0_req_ready}, 64'd0);
      @(negedge clk);
      check("rsp_valid", {p1_rsp_valid, p0_rsp_valid}, (port == 0) ? 64'd1 : 64'd2);
      check("rsp_rdata", (port == 0) ? p0_rsp_rdata : p1_rsp_rdata, exp_rdata);
      check("rsp_err", (port == 0) ? p0_rsp_err : p1_rsp_err, exp_err);
      check("rsp_mem_we_low", mem_we, 1'b0);
      @(negedge clk);
      check("rsp_pulse_end", {p1_rsp_valid, p0_rsp_valid}, 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp_rdy;
      logic [1:0] exp_rsp;
      logic       seen;
      for (int i = 0; i < 1024; i++) mem[i] = i;
      reset_n = 1'b0;
      drive(0, 1'b1, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b1, 1'b0, 32'd0, 32'd0);

      // Reset state: ready held low even with both ports valid
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", {p1_req_ready, p0_req_ready}, 64'd0);
      check("rst_rsp_valid", {p1_rsp_valid, p0_rsp_valid}, 64'd0);
      check("rst_rsp_rdata", {p1_rsp_rdata, p0_rsp_rdata}, 64'd0);
      check("rst_rsp_err", {p1_rsp_err, p0_rsp_err}, 64'd0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_no_valid_ready", {p1_req_ready, p0_req_ready}, 64'd0);

      // Port 0 read of reset contents
      issue(0, 1'b0, 32'd5, 32'd0, 1'b0, 32'd5, 32'h5, 1'b0);

      // Port 1 write, then port 0 reads it back
      issue(1, 1'b1, 32'd3, 32'hDEADBEEF, 1'b1, 32'd3, 32'd0, 1'b0);
      check("mem_word3", mem[3], 32'hDEADBEEF);
      issue(0, 1'b0, 32'd3, 32'd0, 1'b0, 32'd3, 32'hDEADBEEF, 1'b0);

      // Continuous contention from reset: grants alternate starting at port 0
      do_reset();
      drive(0, 1'b1, 1'b0, 32'd10, 32'd0);
      drive(1, 1'b1, 1'b0, 32'd20, 32'd0);
      for (int i = 0; i <= 12; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         exp_rdy = 2'b00;
         exp_rsp = 2'b00;
         if ((i % 2) == 0 && i < 12) exp_rdy = ((i / 2) % 2 == 0) ? 2'b01 : 2'b10;
         if (i == 12) exp_rdy = 2'b01;
         if ((i % 2) == 0 && i >= 2) exp_rsp = (((i / 2) - 1) % 2 == 0) ? 2'b01 : 2'b10;
         check("rr_ready", {p1_req_ready, p0_req_ready}, {62'd0, exp_rdy});
         check("rr_rsp", {p1_rsp_valid, p0_rsp_valid}, {62'd0, exp_rsp});
         if (exp_rsp == 2'b01) check("rr_p0_rdata", p0_rsp_rdata, 32'd10);
         if (exp_rsp == 2'b10) check("rr_p1_rdata", p1_rsp_rdata, 32'd20);
      end
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

      // Reset during the ACCESS cycle of a port 0 write
      drive(0, 1'b1, 1'b1, 32'd7, 32'h12345678);
      #1;
      check("rstacc_ready", {p1_req_ready, p0_req_ready}, 64'd1);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      check("rstacc_we_before", mem_we, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rstacc_we_cut", mem_we, 1'b0);
      @(negedge clk);
      check("rstacc_no_rsp", {p1_rsp_valid, p0_rsp_valid}, 64'd0);
      check("rstacc_mem7", mem[7], 32'd7);
      reset_n = 1'b1;
      drive(0, 1'b1, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b1, 1'b0, 32'd0, 32'd0);
      #1;
      check("rstacc_idle_tie_p0", {p1_req_ready, p0_req_ready}, 64'd1);
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      check("rstacc_still_no_rsp", {p1_rsp_valid, p0_rsp_valid}, 64'd0);

      // Out-of-range write from port 1, then read of word 0
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      issue(1, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b0, 32'd0, 32'd0, 1'b1);
`else
      issue(1, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b1, 32'd1024, 32'd0, 1'b0);
`endif
      issue(0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'h0, 1'b0);

      // Port 0 pulses valid for one cycle while port 1 owns the access
      drive(1, 1'b1, 1'b0, 32'd9, 32'd0);
      #1;
      check("short_p1_ready", {p1_req_ready, p0_req_ready}, 64'd2);
      @(posedge clk);
      #1;
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(0, 1'b1, 1'b1, 32'd11, 32'h55AA55AA);
      @(negedge clk);
      check("short_p0_not_ready", p0_req_ready, 1'b0);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      check("short_p1_rsp", {p1_rsp_valid, p0_rsp_valid}, 64'd2);
      check("short_p1_rdata", p1_rsp_rdata, 32'd9);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (p0_rsp_valid || mem_we) seen = 1'b1;
      end
      check("short_p0_no_access", seen, 1'b0);
      check("short_mem11", mem[11], 32'd11);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
